// File: rtl/rst_pkg.sv
// rst_pkg: reset-cause and sequencer state encodings shared by rst_sequencer and rst_debounce.
package rst_pkg;
  typedef enum logic [2:0] {
    CAUSE_POR = 3'd0,
    CAUSE_KEY = 3'd1,
    CAUSE_PLL = 3'd2,
    CAUSE_SW  = 3'd3,
    CAUSE_WDT = 3'd4
  } cause_t;
  typedef enum logic [2:0] {ASSERT, WAIT_LOCK, HOLD, RELEASE, RUN} state_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rst_debounce.sv
// rst_debounce: synchronises the raw KEY level and emits a one-cycle press on an accepted 1->0 change.
module rst_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic key_press_o
);
  import rst_pkg::*;
  localparam int CW = cw(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, stable_q, stable_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    flip = (s2_q != stable_q) && (cnt_q == LAST);
    cnt_d = (s2_q == stable_q || flip) ? '0 : cnt_q + 1'b1;
    stable_d = flip ? s2_q : stable_q;
    key_press_o = flip && stable_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      stable_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q <= key_n_i;
      s2_q <= s1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: merges PLL/KEY/SW (and watchdog with RST_SEQ_WDT_EN) reset causes and releases
// NUM_STAGES active-low resets one by one after a hold period.
module rst_sequencer #(
  parameter int NUM_STAGES      = 4,
  parameter int HOLD_CYCLES     = 1024,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WDT_CYCLES      = 2**24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked_i,
  input  logic                  key_n_i,
  input  logic                  sw_req_i,
  input  logic                  wdt_kick_i,
  output logic [NUM_STAGES-1:0] stage_resetn_o,
  output logic                  busy_o,
  output logic [2:0]            rst_cause_o
);
  import rst_pkg::*;
  localparam int KW = cw(NUM_STAGES);
  localparam int HW = cw(HOLD_CYCLES);
  localparam int GW = cw(STAGE_GAP);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_STAGES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(STAGE_GAP - 1);
  state_t state_q, state_d;
  cause_t cause_q, cause_d, cause_sel;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [KW-1:0] k_q, k_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic busy_q, key_press, wdt_expire, trig;
  rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk), .reset(reset), .key_n_i(key_n_i), .key_press_o(key_press)
  );
`ifdef RST_SEQ_WDT_EN
  localparam int WW = cw(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  logic [WW-1:0] wdt_q;
  always_ff @(posedge clk) begin
    if (reset || state_q != RUN || wdt_kick_i) wdt_q <= '0;
    else wdt_q <= wdt_q + 1'b1;
  end
  assign wdt_expire = (state_q == RUN) && (wdt_q == WDT_LAST);
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_kick;
  assign unused_kick = wdt_kick_i;
  assign wdt_expire = 1'b0;
`endif
  always_comb begin
    trig = !pll_locked_i || key_press || wdt_expire || sw_req_i;
    cause_sel = !pll_locked_i ? CAUSE_PLL : key_press ? CAUSE_KEY : wdt_expire ? CAUSE_WDT : CAUSE_SW;
    cause_d = trig ? cause_sel : cause_q;
    state_d = state_q;
    hold_d = '0;
    gap_d = '0;
    k_d = k_q;
    case (state_q)
      ASSERT: state_d = WAIT_LOCK;
      WAIT_LOCK: state_d = pll_locked_i ? HOLD : WAIT_LOCK;
      HOLD: begin
        hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + 1'b1;
        k_d = '0;
        if (hold_q == HOLD_LAST) state_d = (NUM_STAGES == 1) ? RUN : RELEASE;
      end
      RELEASE: begin
        gap_d = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
        k_d = (gap_q == GAP_LAST) ? k_q + 1'b1 : k_q;
        state_d = (k_d == K_LAST) ? RUN : RELEASE;
      end
      default: state_d = state_q;
    endcase
    // Triggers in ASSERT/WAIT_LOCK only refresh the cause; the sequence is already restarting.
    if (trig && state_q inside {HOLD, RELEASE, RUN}) state_d = ASSERT;
    stage_d = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      stage_d[i] = (state_d == RUN) || (state_d == RELEASE && i <= int'(k_d));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ASSERT;
      cause_q <= CAUSE_POR;
      hold_q <= '0;
      gap_q <= '0;
      k_q <= '0;
      stage_q <= '0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      hold_q <= hold_d;
      gap_q <= gap_d;
      k_q <= k_d;
      stage_q <= stage_d;
      busy_q <= ~&stage_d;
    end
  end
  assign stage_resetn_o = stage_q;
  assign busy_o = busy_q;
  assign rst_cause_o = cause_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed self-checking bench for rst_sequencer with a scoreboard of expected outputs.
module tb_rst_sequencer;
  logic clk = 1'b0, reset = 1'b1, pll = 1'b1, key_n = 1'b1, sw = 1'b0, kick = 1'b0;
  logic [2:0] stage, cause;
  logic busy;
  int total = 0, bad = 0, cyc = 0;
  bit auto_kick = 1'b1;
  logic [6:0] sb[$];
  always #5 clk = ~clk;
  rst_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(8), .STAGE_GAP(4), .DEBOUNCE_CYCLES(5), .WDT_CYCLES(32)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked_i(pll), .key_n_i(key_n), .sw_req_i(sw),
    .wdt_kick_i(kick), .stage_resetn_o(stage), .busy_o(busy), .rst_cause_o(cause)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    kick = auto_kick && (cyc % 20 == 0);
  endtask
  task automatic expect_out(input logic [2:0] st, input logic [2:0] c);
    sb.push_back({st, st != 3'b111, c});
  endtask
  task automatic sample(input string tag);
    logic [6:0] e, o;
    e = sb.pop_front();
    o = {stage, busy, cause};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: stage/busy/cause got %b want %b", tag, o, e);
    end
  endtask
  task automatic wait_out(input string tag, input logic [2:0] tgt, input int exp_n);
    int n = 0;
    while (stage !== tgt && n < 100) begin
      tick();
      n++;
    end
    total++;
    assert (n === exp_n) else begin
      bad++;
      $error("FAIL %s: cycles to stage %b got %0d want %0d", tag, tgt, n, exp_n);
    end
  endtask
  initial begin
    expect_out(3'b000, 3'd0);
    repeat (3) tick();
    sample("reset");
    reset = 1'b0;
    wait_out("t1_stage0", 3'b001, 10);
    wait_out("t1_stage1", 3'b011, 4);
    wait_out("t1_stage2", 3'b111, 4);
    expect_out(3'b111, 3'd0);
    sample("t1_run");
    key_n = 1'b0;
    expect_out(3'b111, 3'd0);
    repeat (3) tick();
    key_n = 1'b1;
    repeat (12) tick();
    sample("t2_short_key");
    key_n = 1'b0;
    wait_out("t2_press", 3'b000, 7);
    expect_out(3'b000, 3'd1);
    sample("t2_cause");
    repeat (3) tick();
    key_n = 1'b1;
    wait_out("t2_replay", 3'b001, 7);
    pll = 1'b0;
    expect_out(3'b000, 3'd2);
    tick();
    sample("t3_drop");
    expect_out(3'b000, 3'd2);
    repeat (15) tick();
    sample("t3_wait_lock");
    pll = 1'b1;
    wait_out("t3_relock", 3'b001, 9);
    wait_out("t3_stage1", 3'b011, 4);
    wait_out("t3_stage2", 3'b111, 4);
    expect_out(3'b111, 3'd2);
    sample("t3_run");
    pll = 1'b0;
    sw = 1'b1;
    expect_out(3'b000, 3'd2);
    tick();
    pll = 1'b1;
    sw = 1'b0;
    sample("t4_pll_and_sw");
    wait_out("t4_single", 3'b001, 10);
    wait_out("t4_stage1", 3'b011, 4);
    wait_out("t4_stage2", 3'b111, 4);
    sw = 1'b1;
    expect_out(3'b000, 3'd3);
    tick();
    sw = 1'b0;
    sample("t4_sw");
    wait_out("t4_sw_s0", 3'b001, 10);
    wait_out("t4_sw_s1", 3'b011, 4);
    wait_out("t4_sw_s2", 3'b111, 4);
`ifdef RST_SEQ_WDT_EN
    expect_out(3'b111, 3'd3);
    repeat (100) tick();
    sample("t5_kicked");
    for (int i = 0; i < 25 && !kick; i++) tick();
    auto_kick = 1'b0;
    tick();
    wait_out("t5_expire", 3'b000, 32);
    expect_out(3'b000, 3'd4);
    sample("t5_cause");
    auto_kick = 1'b1;
`else
    expect_out(3'b111, 3'd3);
    repeat (150) tick();
    sample("t5_no_wdt");
    sw = 1'b1;
    expect_out(3'b000, 3'd3);
    tick();
    sw = 1'b0;
    sample("t5_sw");
`endif
    wait_out("t6_s0", 3'b001, 10);
    wait_out("t6_s1", 3'b011, 4);
    reset = 1'b1;
    expect_out(3'b000, 3'd0);
    tick();
    reset = 1'b0;
    sample("t6_reset");
    wait_out("t6_restart", 3'b001, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
